writeback_stage: RTL and testbench

Final stage of the five-stage pipeline. Holds the MEM/WB pipeline register, selects between the data-memory read value and the ALU result, and drives the register-file write port. It also supplies the MEM/WB operands to the forwarding unit, counts retired instructions, and latches a sticky halted state when a halt instruction retires.

---
 rtl/writeback_stage_if.sv | 35 +++
 rtl/writeback_stage.sv | 87 ++++++++
 tb/tb_writeback_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// MEM/WB bundle between the memory stage and the write-back stage: pipeline
// inputs, hold/flush control, and the register-file/forwarding outputs.
interface writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] memReadData;
  logic [DATA_W-1:0] aluResultIn;
  logic [REG_W-1:0]  regSelIn;
  logic              memToRegIn;
  logic              regWriteIn;
  logic              haltIn;
  logic              validIn;
  logic              hold;
  logic              flush;

  logic [DATA_W-1:0] writeData;
  logic [REG_W-1:0]  writeAddr;
  logic              regWrite;
  logic [CNT_W-1:0]  retireCount;
  logic              halted;

  modport master (
    output memReadData, aluResultIn, regSelIn, memToRegIn, regWriteIn,
           haltIn, validIn, hold, flush,
    input  writeData, writeAddr, regWrite, retireCount, halted
  );

  modport slave (
    input  memReadData, aluResultIn, regSelIn, memToRegIn, regWriteIn,
           haltIn, validIn, hold, flush,
    output writeData, writeAddr, regWrite, retireCount, halted
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, write-back mux, register-file write
// port, retired-instruction counter and sticky HALT state.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  writeback_stage_if.slave  wb
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  reg_sel;
    logic              mem_to_reg;
    logic              reg_write;
    logic              halt;
    logic              valid;
  } mw_t;

  mw_t              mw_q, mw_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             commit;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mw_d = mw_q;
    if (wb.flush) begin
      // Data fields are don't-care for a bubble; only the control bits matter.
      mw_d.valid     = 1'b0;
      mw_d.reg_write = 1'b0;
      mw_d.halt      = 1'b0;
    end else if (!wb.hold) begin
      mw_d.read_data  = wb.memReadData;
      mw_d.alu_result = wb.aluResultIn;
      mw_d.reg_sel    = wb.regSelIn;
      mw_d.mem_to_reg = wb.memToRegIn;
      mw_d.reg_write  = wb.regWriteIn;
      mw_d.halt       = wb.haltIn;
      mw_d.valid      = wb.validIn;
    end
  end

  // Retirement and the halt decision look at the entry currently in MEM/WB;
  // a flush on the same edge only affects what gets loaded next.
  assign commit = mw_q.valid && !wb.hold && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (commit) begin
      count_d = count_q + CNT_W'(1);
      if (mw_q.halt) state_d = HALTED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      mw_q    <= '0;
      state_q <= RUN;
      count_q <= '0;
    end else begin
      mw_q    <= mw_d;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign wb.writeData   = mw_q.mem_to_reg ? mw_q.read_data : mw_q.alu_result;
  assign wb.writeAddr   = mw_q.reg_sel;
  assign wb.regWrite    = mw_q.valid && mw_q.reg_write && (mw_q.reg_sel != '0)
                          && (state_q == RUN);
  assign wb.retireCount = count_q;
  assign wb.halted      = (state_q == HALTED);

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: a vector table driven through a
// scoreboard queue, plus a counter-wrap sequence on a 4-bit-counter instance.
module tb_writeback_stage;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic rst4  = 1'b1;

  always #5 clock = ~clock;

  writeback_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(32)) bus ();
  writeback_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  bus4 ();

  writeback_stage #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
    .clock (clock),
    .reset (rst),
    .wb    (bus.slave)
  );

  writeback_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
    .clock (clock),
    .reset (rst4),
    .wb    (bus4.slave)
  );

  typedef struct {
    logic        rst, hold, flush, valid, rw, halt, m2r;
    logic [4:0]  sel;
    logic [31:0] alu, rd;
    logic        chk_data;
    logic [31:0] e_wd;
    logic [4:0]  e_wa;
    logic        e_rw;
    logic [31:0] e_cnt;
    logic        e_halt;
  } vec_t;

  typedef struct {
    logic        chk_data;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        rw;
    logic [31:0] cnt;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[23];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(
    input logic rst_v, hold_v, flush_v, valid_v, rw_v, halt_v, m2r_v,
    input logic [4:0] sel_v, input logic [31:0] alu_v, rd_v,
    input logic chk_v, input logic [31:0] wd_v, input logic [4:0] wa_v,
    input logic erw_v, input logic [31:0] cnt_v, input logic ehalt_v);
    vec_t v;
    v.rst = rst_v;  v.hold = hold_v; v.flush = flush_v; v.valid = valid_v;
    v.rw = rw_v;    v.halt = halt_v; v.m2r = m2r_v;     v.sel = sel_v;
    v.alu = alu_v;  v.rd = rd_v;     v.chk_data = chk_v;
    v.e_wd = wd_v;  v.e_wa = wa_v;   v.e_rw = erw_v;    v.e_cnt = cnt_v;
    v.e_halt = ehalt_v;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    rst              = v.rst;
    bus.hold         = v.hold;
    bus.flush        = v.flush;
    bus.validIn      = v.valid;
    bus.regWriteIn   = v.rw;
    bus.haltIn       = v.halt;
    bus.memToRegIn   = v.m2r;
    bus.regSelIn     = v.sel;
    bus.aluResultIn  = v.alu;
    bus.memReadData  = v.rd;
    exp_q.push_back('{chk_data: v.chk_data, wd: v.e_wd, wa: v.e_wa,
                      rw: v.e_rw, cnt: v.e_cnt, halt: v.e_halt});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    if (e.chk_data) begin
      check($sformatf("v%0d writeData", idx), 64'(bus.writeData), 64'(e.wd));
      check($sformatf("v%0d writeAddr", idx), 64'(bus.writeAddr), 64'(e.wa));
    end
    check($sformatf("v%0d regWrite", idx), 64'(bus.regWrite), 64'(e.rw));
    check($sformatf("v%0d retireCount", idx), 64'(bus.retireCount), 64'(e.cnt));
    check($sformatf("v%0d halted", idx), 64'(bus.halted), 64'(e.halt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    {bus.hold, bus.flush, bus.validIn, bus.regWriteIn, bus.haltIn, bus.memToRegIn} = '0;
    bus.regSelIn = '0; bus.aluResultIn = '0; bus.memReadData = '0;
    {bus4.hold, bus4.flush, bus4.validIn, bus4.regWriteIn, bus4.haltIn, bus4.memToRegIn} = '0;
    bus4.regSelIn = '0; bus4.aluResultIn = '0; bus4.memReadData = '0;

    //            rst h  f  v  rw ht m2r sel alu           rd            chk wd            wa rw cnt ht
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 1, 0, 0, 8,  32'h2A,       32'h0,        1, 32'h2A,       8, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 1, 0, 1, 3,  32'h5,        32'hDEADBEEF, 1, 32'hDEADBEEF, 3, 1, 1, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 0, 1, 0,  32'h5,        32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 2, 0);
    vecs[4]  = mk(0, 0, 0, 1, 1, 0, 0, 4,  32'h11,       32'hFFFF0000, 1, 32'h11,       4, 1, 3, 0);
    vecs[5]  = mk(0, 1, 0, 1, 1, 0, 0, 9,  32'h99,       32'h0,        1, 32'h11,       4, 1, 3, 0);
    vecs[6]  = mk(0, 1, 0, 1, 1, 0, 0, 9,  32'h99,       32'h0,        1, 32'h11,       4, 1, 3, 0);
    vecs[7]  = mk(0, 1, 0, 1, 1, 0, 0, 9,  32'h99,       32'h0,        1, 32'h11,       4, 1, 3, 0);
    vecs[8]  = mk(0, 0, 0, 1, 1, 0, 0, 5,  32'h22,       32'h0,        1, 32'h22,       5, 1, 4, 0);
    // flush together with hold: bubble next, held entry never counted
    vecs[9]  = mk(0, 1, 1, 1, 1, 0, 0, 6,  32'h33,       32'h0,        0, 32'h0,        0, 0, 4, 0);
    // bubble carrying write+halt bits must stay inert
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 0, 7,  32'h44,       32'h0,        1, 32'h44,       7, 0, 4, 0);
    vecs[11] = mk(0, 0, 0, 1, 1, 0, 0, 1,  32'h55,       32'h0,        1, 32'h55,       1, 1, 4, 0);
    vecs[12] = mk(0, 0, 0, 1, 1, 0, 0, 2,  32'h66,       32'h0,        1, 32'h66,       2, 1, 5, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, 1, 0, 0,  32'h0,        32'h0,        1, 32'h0,        0, 0, 6, 0);
    vecs[14] = mk(0, 1, 0, 1, 1, 0, 0, 5,  32'h77,       32'h0,        1, 32'h0,        0, 0, 6, 0);
    vecs[15] = mk(0, 0, 0, 1, 1, 0, 0, 5,  32'h77,       32'h0,        1, 32'h77,       5, 0, 7, 1);
    vecs[16] = mk(0, 0, 0, 1, 1, 0, 0, 6,  32'h88,       32'h0,        1, 32'h88,       6, 0, 7, 1);
    vecs[17] = mk(1, 1, 1, 1, 1, 1, 0, 6,  32'h88,       32'h0,        1, 32'h0,        0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 1, 1, 0, 0, 7,  32'hAB,       32'h0,        1, 32'hAB,       7, 1, 0, 0);
    vecs[19] = mk(0, 1, 0, 1, 1, 0, 0, 9,  32'hCD,       32'h0,        1, 32'hAB,       7, 1, 0, 0);
    vecs[20] = mk(1, 1, 0, 1, 1, 0, 0, 9,  32'hCD,       32'h0,        1, 32'h0,        0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 1, 0, 1, 0, 0,  32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 0);
    // HALT retires on the same edge as a flush
    vecs[22] = mk(0, 0, 1, 1, 1, 0, 0, 3,  32'hEE,       32'h0,        0, 32'h0,        0, 0, 1, 1);

    for (int i = 0; i < 23; i++) apply(vecs[i], i);

    // 4-bit counter wrap: 17 back-to-back valid writes, then a bubble.
    @(negedge clock);
    rst4 = 1'b0;
    bus4.regWriteIn = 1'b1;
    bus4.regSelIn   = 5'd1;
    for (int e = 1; e <= 18; e++) begin
      bus4.validIn     = (e <= 17);
      bus4.aluResultIn = 32'(e);
      @(posedge clock);
      #1;
      if (e == 1)  check("wrap start", 64'(bus4.retireCount), 64'd0);
      if (e == 16) check("wrap at 15", 64'(bus4.retireCount), 64'd15);
      if (e == 17) check("wrap to 0",  64'(bus4.retireCount), 64'd0);
      if (e == 18) check("wrap to 1",  64'(bus4.retireCount), 64'd1);
    end
    check("wrap halted", 64'(bus4.halted), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
